keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a ROWS x COLS matrix keypad one row at a time, debounces a single
//   key press, and reports press, auto-repeat and release events through a
//   small event FIFO with a valid/ready handshake.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous reset, active low
//   keyPad_col  column sense, 0 = key pressed on the driven row
//   keyPad_row  row drive, one-hot active low
//   repeat_en   allow auto-repeat events while a key is held
//   key_ready   consumer takes the head event
//   key_valid   event FIFO not empty
//   key_code    head event key index (row*COLS + col)
//   key_kind    head event type: 00 press, 01 repeat, 10 release
//   overflow    one-cycle pulse when an event is dropped on a full FIFO
//
// Debounce FSM
//   state      | meaning
//   IDLE       | no key accepted, waiting for a single pressed key
//   PRESS_DB   | same key must persist for DEBOUNCE scans before press
//   HELD       | key accepted, auto-repeat timing runs here
//   RELEASE_DB | key gone for fewer than DEBOUNCE scans
module keypad_scan_ctrl #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 250,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 40,
  parameter int REPEAT_RATE  = 10,
  parameter int DEPTH        = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [COLS-1:0]                 keyPad_col,
  output logic [ROWS-1:0]                 keyPad_row,
  input  logic                            repeat_en,
  input  logic                            key_ready,
  output logic                            key_valid,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic [1:0]                      key_kind,
  output logic                            overflow
);

  localparam int NKEYS   = ROWS * COLS;
  localparam int KW      = $clog2(NKEYS);
  localparam int RW      = $clog2(ROWS);
  localparam int DW      = $clog2(SCAN_DIV);
  localparam int AW      = $clog2(DEPTH);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int PW      = $clog2(REP_MAX + 1);

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_REPEAT  = 2'b01;
  localparam logic [1:0] KIND_RELEASE = 2'b10;

  localparam logic [3:0]    DB_N    = 4'(DEBOUNCE);
  localparam logic [PW-1:0] RD_N    = PW'(REPEAT_DELAY);
  localparam logic [PW-1:0] RR_N    = PW'(REPEAT_RATE);
  localparam logic [RW-1:0] ROW_END = RW'(ROWS - 1);
  localparam logic [DW-1:0] DIV_END = DW'(SCAN_DIV - 1);

  // ---------------------------------------------------------------- scanner
  logic [DW-1:0]    div_cnt;
  logic [RW-1:0]    row_idx;
  logic [NKEYS-1:0] snap;
  logic             scan_done;
  logic             dwell_end;

  assign dwell_end = (div_cnt == DIV_END);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      row_idx   <= '0;
      snap      <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= dwell_end && (row_idx == ROW_END);
      if (dwell_end) begin
        div_cnt <= '0;
        row_idx <= (row_idx == ROW_END) ? '0 : row_idx + RW'(1);
        for (int i = 0; i < ROWS; i++) begin
          if (row_idx == RW'(i)) snap[i*COLS +: COLS] <= ~keyPad_col;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    keyPad_row = '1;
    for (int i = 0; i < ROWS; i++) begin
      if (row_idx == RW'(i)) keyPad_row[i] = 1'b0;
    end
  end

  // Candidate is valid only when exactly one key is down (power-of-two test).
  logic          cand_ok;
  logic [KW-1:0] cand_now;

  always_comb begin
    cand_now = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (snap[i]) cand_now = KW'(i);
    end
    cand_ok = (snap != '0) && ((snap & (snap - NKEYS'(1))) == '0);
  end

  // --------------------------------------------------------------- debounce
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] cand, cand_nxt;
  logic [3:0]    db_cnt, db_nxt;
  logic [PW-1:0] rep_cnt, rep_nxt;
  logic          rep_armed, rep_armed_nxt;  // first REPEAT_DELAY has elapsed
  logic          push;
  logic [1:0]    push_kind;
  logic [KW-1:0] push_code;
  logic          same;

  assign same = cand_ok && (cand_now == cand);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cand      <= '0;
      db_cnt    <= '0;
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      db_cnt    <= db_nxt;
      rep_cnt   <= rep_nxt;
      rep_armed <= rep_armed_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cand_nxt      = cand;
    db_nxt        = db_cnt;
    rep_nxt       = rep_cnt;
    rep_armed_nxt = rep_armed;
    push          = 1'b0;
    push_kind     = KIND_PRESS;
    push_code     = cand;

    if (scan_done) begin
      case (state)
        IDLE: begin
          if (cand_ok) begin
            cand_nxt  = cand_now;
            push_code = cand_now;
            if (DB_N == 4'd1) begin
              push          = 1'b1;
              rep_nxt       = '0;
              rep_armed_nxt = 1'b0;
              db_nxt        = '0;
              state_nxt     = HELD;
            end else begin
              db_nxt    = 4'd1;
              state_nxt = PRESS_DB;
            end
          end
        end

        PRESS_DB: begin
          if (same) begin
            if (db_cnt + 4'd1 == DB_N) begin
              push          = 1'b1;
              rep_nxt       = '0;
              rep_armed_nxt = 1'b0;
              db_nxt        = '0;
              state_nxt     = HELD;
            end else begin
              db_nxt = db_cnt + 4'd1;
            end
          end else begin
            db_nxt    = '0;
            state_nxt = IDLE;
          end
        end

        HELD: begin
          if (!same) begin
            if (DB_N == 4'd1) begin
              push      = 1'b1;
              push_kind = KIND_RELEASE;
              db_nxt    = '0;
              state_nxt = IDLE;
            end else begin
              db_nxt    = 4'd1;
              state_nxt = RELEASE_DB;
            end
          end else if (repeat_en) begin
            if (rep_cnt + PW'(1) == (rep_armed ? RR_N : RD_N)) begin
              push          = 1'b1;
              push_kind     = KIND_REPEAT;
              rep_nxt       = '0;
              rep_armed_nxt = 1'b1;
            end else begin
              rep_nxt = rep_cnt + PW'(1);
            end
          end else begin
            rep_nxt = '0;
          end
        end

        RELEASE_DB: begin
          if (same) begin
            // Bounce back: repeat timing resumes where it left off.
            db_nxt    = '0;
            state_nxt = HELD;
          end else if (db_cnt + 4'd1 == DB_N) begin
            push      = 1'b1;
            push_kind = KIND_RELEASE;
            db_nxt    = '0;
            state_nxt = IDLE;
          end else begin
            db_nxt = db_cnt + 4'd1;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- event FIFO
  logic [KW+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;

  assign key_valid = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = key_valid && key_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) begin
        mem[wr_ptr] <= {push_kind, push_code};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign key_code = key_valid ? mem[rd_ptr][KW-1:0]    : '0;
  assign key_kind = key_valid ? mem[rd_ptr][KW+1:KW]   : 2'b00;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int RD   = 4;
  localparam int RR   = 2;
  localparam int DP   = 4;
  localparam int SCAN = R * SD;

  logic        clock = 1'b0;
  logic        reset;
  logic [C-1:0] keyPad_col;
  logic [R-1:0] keyPad_row;
  logic        repeat_en;
  logic        key_ready;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [1:0]  key_kind;
  logic        overflow;

  keypad_scan_ctrl #(
    .ROWS(R), .COLS(C), .SCAN_DIV(SD), .DEBOUNCE(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .DEPTH(DP)
  ) dut (
    .clock(clock), .reset(reset), .keyPad_col(keyPad_col), .keyPad_row(keyPad_row),
    .repeat_en(repeat_en), .key_ready(key_ready), .key_valid(key_valid),
    .key_code(key_code), .key_kind(key_kind), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its column to its row line.
  logic [15:0] pressed;
  always_comb begin
    keyPad_col = '1;
    for (int r = 0; r < R; r++)
      if (keyPad_row[r] == 1'b0)
        for (int c = 0; c < C; c++)
          if (pressed[r*C + c]) keyPad_col[c] = 1'b0;
  end

  int ecnt;
  always @(posedge clock or negedge reset)
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  typedef struct { int kind; int code; int at; } evt_t;
  evt_t exp_q[$];
  evt_t obs_q[$];
  int   ovf_seen;

  always @(negedge clock) begin
    if (reset === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1)
      obs_q.push_back('{int'(key_kind), int'(key_code), ecnt});
    if (reset === 1'b1 && overflow === 1'b1) ovf_seen++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model: works on whole-scan key sets and per-key scan counts.
  int m_held, m_pend, m_n, m_away, m_t, m_scan;

  task automatic model_reset();
    m_held = -1; m_pend = -1; m_n = 0; m_away = 0; m_t = 0; m_scan = 0;
    exp_q.delete();
  endtask

  function automatic int cand_of(input logic [15:0] s);
    if ($countones(s) != 1) return -1;
    for (int i = 0; i < 16; i++) if (s[i]) return i;
    return -1;
  endfunction

  task automatic add(input int kind, input int code);
    exp_q.push_back('{kind, code, SCAN * m_scan + 1});
  endtask

  task automatic model_scan(input logic [15:0] s);
    int c;
    c = cand_of(s);
    m_scan++;
    if (m_held < 0) begin
      if (m_pend < 0) begin
        if (c >= 0) begin m_pend = c; m_n = 1; end
      end else if (c == m_pend) m_n++;
      else m_pend = -1;
      if (m_pend >= 0 && m_n >= DB) begin
        add(0, m_pend); m_held = m_pend; m_pend = -1; m_away = 0; m_t = 0;
      end
    end else if (c != m_held) begin
      m_away++;
      if (m_away >= DB) begin add(2, m_held); m_held = -1; end
    end else if (m_away > 0) begin
      m_away = 0;
    end else if (repeat_en) begin
      m_t++;
      if (m_t >= RD && (m_t - RD) % RR == 0) add(1, m_held);
    end
  endtask

  // One full scan with a fixed key set; starts and ends on a scan boundary.
  task automatic step(input logic [15:0] s);
    model_scan(s);
    pressed = s;
    repeat (SCAN) @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_reset();
    obs_q.delete();
    ovf_seen = 0;
  endtask

  task automatic cmp_events(input string tag, input bit chk_at);
    repeat (2) @(negedge clock);
    chk({tag, ".count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s.kind[%0d]", tag, i), obs_q[i].kind, exp_q[i].kind);
      chk($sformatf("%s.code[%0d]", tag, i), obs_q[i].code, exp_q[i].code);
      if (chk_at) chk($sformatf("%s.at[%0d]", tag, i), obs_q[i].at, exp_q[i].at);
    end
  endtask

  function automatic logic [15:0] k1(input int k);
    logic [15:0] one;
    one = 16'd1;
    return one << k;
  endfunction

  int k, k2, n, reps;

  initial begin
    reset = 1'b0; pressed = '0; repeat_en = 1'b0; key_ready = 1'b1;
    ovf_seen = 0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clock);
    chk("rst.row",   keyPad_row, 4'b1110);
    chk("rst.valid", key_valid, 0);
    chk("rst.code",  key_code, 0);
    chk("rst.kind",  key_kind, 0);
    chk("rst.ovf",   overflow, 0);

    // Scenario 1: idle scanning
    apply_reset();
    for (int m = 0; m < 2 * SCAN; m++) begin
      chk($sformatf("s1.row[%0d]", m), keyPad_row, 4'hF & ~(4'h1 << ((m / SD) % R)));
      chk($sformatf("s1.valid[%0d]", m), key_valid, 0);
      @(negedge clock);
    end

    // Scenario 2: key 9 for 5 scans, then released for 3
    apply_reset();
    repeat (5) step(k1(9));
    repeat (3) step(16'h0);
    repeat (2) @(negedge clock);
    chk("s2.n", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("s2.press.kind", obs_q[0].kind, 0);
      chk("s2.press.code", obs_q[0].code, 9);
      chk("s2.press.at",   obs_q[0].at, 3 * SCAN + 1);
      chk("s2.rel.kind",   obs_q[1].kind, 2);
      chk("s2.rel.code",   obs_q[1].code, 9);
      chk("s2.rel.at",     obs_q[1].at, 8 * SCAN + 1);
    end
    chk("s2.model", exp_q.size(), 2);

    // Scenario 3: short press, then a fresh key must be accepted from IDLE
    apply_reset();
    repeat (2) step(k1(9));
    repeat (2) step(16'h0);
    repeat (3) step(k1(6));
    cmp_events("s3", 1'b1);

    // Scenario 4: auto-repeat
    apply_reset();
    repeat_en = 1'b1;
    repeat (15) step(k1(5));
    repeat (3) step(16'h0);
    reps = 0;
    foreach (exp_q[i]) if (exp_q[i].kind == 1) reps++;
    chk("s4.model.reps", reps, 5);
    cmp_events("s4", 1'b1);
    repeat_en = 1'b0;

    // Scenario 5: multi-key gives no candidate; second key forces release
    apply_reset();
    repeat (4) step(k1(3) | k1(7));
    step(16'h0);
    repeat (4) step(k1(3));
    repeat (3) step(k1(3) | k1(7));
    repeat (2) step(16'h0);
    cmp_events("s5", 1'b1);

    // Scenario 6: consumer stalled, FIFO fills, one event dropped
    apply_reset();
    key_ready = 1'b0;
    repeat_en = 1'b1;
    k = $urandom_range(0, 15);
    repeat (8) step(k1(k));
    chk("s6.hold.kind", key_kind, 0);
    chk("s6.hold.code", key_code, k);
    repeat (5) step(k1(k));
    repeat (2) @(negedge clock);
    chk("s6.ovf", ovf_seen, 1);
    chk("s6.valid", key_valid, 1);
    chk("s6.head.kind", key_kind, 0);
    chk("s6.head.code", key_code, k);
    repeat_en = 1'b0;
    exp_q = exp_q[0:DP-1];
    key_ready = 1'b1;
    repeat (6) @(negedge clock);
    chk("s6.drained", key_valid, 0);
    cmp_events("s6", 1'b0);

    // Reset while a key is held: no release, scan restarts at row 0
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst2.valid", key_valid, 0);
    chk("rst2.row", keyPad_row, 4'b1110);
    pressed = '0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    obs_q.delete();
    chk("rst2.row0", keyPad_row, 4'b1110);
    repeat (SD) @(negedge clock);
    chk("rst2.row1", keyPad_row, 4'b1101);
    repeat (SCAN - SD) @(negedge clock);
    repeat (4) step(16'h0);
    cmp_events("rst2", 1'b1);

    // Randomized key activity against the model
    apply_reset();
    for (int t = 0; t < 25; t++) begin
      repeat_en = 1'($urandom_range(0, 1));
      k  = $urandom_range(0, 15);
      k2 = (k + $urandom_range(1, 15)) % 16;
      n  = $urandom_range(1, 8);
      case ($urandom_range(0, 3))
        0: repeat (n) step(k1(k));
        1: begin
          repeat (n) step(k1(k));
          repeat ($urandom_range(1, 2)) step(16'h0);
          repeat ($urandom_range(1, 6)) step(k1(k));
        end
        2: begin
          repeat (n) step(k1(k));
          repeat ($urandom_range(1, 5)) step(k1(k) | k1(k2));
        end
        default: begin
          repeat (n) step(k1(k));
          repeat ($urandom_range(1, 5)) step(k1(k2));
        end
      endcase
      repeat ($urandom_range(3, 5)) step(16'h0);
    end
    cmp_events("rnd", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
